// File: rtl/md_unit_ctrl_pkg.sv
// md_unit_ctrl_pkg
// Shared definitions for the E-stage multiply/divide sequencer:
//   - MD_* 3-bit op encodings carried on md_op
//   - default busy latencies for multiply and divide
//   - sequencer FSM state type
//   - small op-class helper functions
package md_unit_ctrl_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
// E-stage <-> multiply/divide sequencer connection.
//   start     issue strobe for an md op in E
//   md_op     MD_* op encoding
//   rs_data   forwarded rs operand
//   rt_data   forwarded rt operand
//   flush     E-stage exception/eret flush
//   md_use_d  D-stage instruction touches HI/LO
//   busy      long op in flight
//   stall_md  D-stage stall request
//   hi, lo    architectural HI/LO
// master = pipeline side, slave = sequencer side.
interface md_unit_ctrl_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_data, rt_data, flush, md_use_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, rs_data, rt_data, flush, md_use_d,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_unit_ctrl_compute.sv
// md_unit_ctrl_compute (md_compute datapath)
// Combinational 32x32 multiply/divide producing the 64-bit {hi,lo} result.
//   i_op            MD_* op encoding
//   i_rs, i_rt      operands
//   o_result        {hi,lo}: product, or {remainder, quotient} for divides
//   o_div_by_zero   divide op with rt == 0 (result must not be committed)
module md_unit_ctrl_compute
    import md_unit_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_result,
    output logic        o_div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows:
    // the magnitude quotient 0x80000000 is already the wrapped answer.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_rs_neg     = w_signed_div & i_rs[31];
    assign w_rt_neg     = w_signed_div & i_rt[31];
    assign w_rs_mag     = w_rs_neg ? (32'd0 - i_rs) : i_rs;
    assign w_rt_mag     = w_rt_neg ? (32'd0 - i_rt) : i_rt;
    // Dummy divisor keeps the divider defined; the result is discarded anyway.
    assign w_divisor    = (w_rt_mag == 32'd0) ? 32'd1 : w_rt_mag;
    assign w_q_mag      = w_rs_mag / w_divisor;
    assign w_r_mag      = w_rs_mag % w_divisor;
    assign w_quot       = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_result = 64'd0;
        if (i_op == MD_MULT) begin
            o_result = w_prod_s;
        end else if (i_op == MD_MULTU) begin
            o_result = w_prod_u;
        end else if (md_is_div(i_op)) begin
            o_result = {w_rem, w_quot};
        end
    end

    assign o_div_by_zero = md_is_div(i_op) & (i_rt == 32'd0);

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
// Multiply/divide sequencer for the E stage. Owns HI/LO, holds busy for a
// fixed latency per op and raises the D-stage stall for HI/LO users.
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   md      md_unit_ctrl_if.slave (start/md_op/operands/flush/md_use_d in,
//           busy/stall_md/hi/lo out)
// The result is computed at issue and parked in a pending register; HI/LO
// only change on the completion edge, so a flush or reset cannot leave them
// half-written.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    md_unit_ctrl_if.slave md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [63:0]      r_pend, w_pend_d;
    logic             r_pend_dbz, w_pend_dbz_d;
    logic [31:0]      r_hi, w_hi_d;
    logic [31:0]      r_lo, w_lo_d;
    logic             r_busy, w_busy_d;

    logic             w_issue;
    logic             w_issue_long;
    logic [63:0]      w_result;
    logic             w_dbz;

    assign w_issue      = md.start & ~md.flush & (r_state == StIdle);
    assign w_issue_long = w_issue & (md_is_mul(md.md_op) | md_is_div(md.md_op));

    md_unit_ctrl_compute u_compute (
        .i_op          (md.md_op),
        .i_rs          (md.rs_data),
        .i_rt          (md.rt_data),
        .o_result      (w_result),
        .o_div_by_zero (w_dbz)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_pend     <= 64'd0;
            r_pend_dbz <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_pend     <= w_pend_d;
            r_pend_dbz <= w_pend_dbz_d;
            r_hi       <= w_hi_d;
            r_lo       <= w_lo_d;
            r_busy     <= w_busy_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_pend_d     = r_pend;
        w_pend_dbz_d = r_pend_dbz;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;

        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    if (md_is_mul(md.md_op)) begin
                        w_state_d    = StMul;
                        w_cnt_d      = MUL_LOAD;
                        w_pend_d     = w_result;
                        w_pend_dbz_d = 1'b0;
                    end else if (md_is_div(md.md_op)) begin
                        w_state_d    = StDiv;
                        w_cnt_d      = DIV_LOAD;
                        w_pend_d     = w_result;
                        w_pend_dbz_d = w_dbz;
                    end else if (md.md_op == MD_MTHI) begin
                        w_hi_d = md.rs_data;
                    end else if (md.md_op == MD_MTLO) begin
                        w_lo_d = md.rs_data;
                    end
                end
            end
            StMul, StDiv: begin
                // Flush is deliberately ignored here: an op in flight always completes.
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                    if (!r_pend_dbz) begin
                        w_hi_d = r_pend[63:32];
                        w_lo_d = r_pend[31:0];
                    end
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    assign md.busy     = r_busy;
    // Stall in the issue cycle too, before busy has had a chance to register.
    assign md.stall_md = md.md_use_d & (r_busy | w_issue_long);
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl
// Bench for md_unit_ctrl: a table of single-op vectors with fixed expected
// HI/LO, hand-written sequences for timing/stall/flush/reset corners, and a
// randomized run, all cross-checked every cycle against a cycle-count model.
module tb_md_unit_ctrl;
    import md_unit_ctrl_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .md    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: remaining busy cycles plus the committed/pending register values.
    int          m_left = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [63:0] m_pend = 64'd0;
    bit          m_skip = 1'b0;

    logic s_busy;
    logic s_stall;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'd0;
        case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b != 32'd0) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, clock, advance model.
    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input bit fl, input bit md_use);
        bit issue;
        bit long_op;
        bus.start    = st;
        bus.md_op    = op;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        bus.flush    = fl;
        bus.md_use_d = md_use;
        #1;
        issue   = st && !fl && (m_left == 0);
        long_op = issue && (op >= MD_MULT) && (op <= MD_DIVU);
        if (st && !fl && m_left != 0) begin
            errors++;
            $display("FAIL start_while_busy actual=start required=no_start at %0t", $time);
        end
        s_busy  = bus.busy;
        s_stall = bus.stall_md;
        check1("busy", bus.busy, m_left != 0);
        check1("stall_md", bus.stall_md, md_use && (m_left != 0 || long_op));
        check32("hi", bus.hi, m_hi);
        check32("lo", bus.lo, m_lo);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_skip) {m_hi, m_lo} = m_pend;
        end else if (issue) begin
            if (long_op) begin
                m_left = (op <= MD_MULTU) ? MC : DC;
                m_pend = ref_md(op, rs, rt);
                m_skip = (op >= MD_DIV) && (rt == 32'd0);
            end else if (op == MD_MTHI) begin
                m_hi = rs;
            end else if (op == MD_MTLO) begin
                m_lo = rs;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit md_use);
        for (int i = 0; i < n; i++) step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, md_use);
    endtask

    // Called mid-cycle; reset must clear outputs without waiting for a clock edge.
    task automatic pulse_reset();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        rst = 1'b1;
        #1;
        check1("rst_busy", bus.busy, 1'b0);
        check32("rst_hi", bus.hi, 32'd0);
        check32("rst_lo", bus.lo, 32'd0);
        m_left = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5]  = '{MD_MTHI,  32'h00000011, 32'h00000000, 32'h00000011, 32'h00000003};
        vecs[6]  = '{MD_MTLO,  32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022};
        vecs[7]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022};
        vecs[8]  = '{MD_DIV,   32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022};
        vecs[9]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{MD_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{MD_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[12] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[13] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[14] = '{MD_RSVD,  32'h12345678, 32'h00000001, 32'h0000000F, 32'h0FFFFFFF};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.md_op    = MD_NONE;
        bus.rs_data  = 32'd0;
        bus.rt_data  = 32'd0;
        bus.flush    = 1'b0;
        bus.md_use_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check1("reset_busy", bus.busy, 1'b0);
        check1("reset_stall", bus.stall_md, 1'b0);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Busy window and result latency for a multiply.
        step(1'b1, MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        check1("t0_busy", s_busy, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
            check1("mul_busy_window", s_busy, k <= 5);
        end
        check32("mul_hi_t6", bus.hi, 32'hFFFFFFFF);
        check32("mul_lo_t6", bus.lo, 32'hFFFFFFFA);

        // Table: issue each op, wait its latency, compare fixed HI/LO.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0);
            if (md_is_mul(vecs[i].op)) idle(MC, 1'b0);
            else if (md_is_div(vecs[i].op)) idle(DC, 1'b0);
            check32("vec_hi", bus.hi, vecs[i].hi);
            check32("vec_lo", bus.lo, vecs[i].lo);
        end

        // Stall covers the issue cycle and every busy cycle, then drops.
        step(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
        check1("stall_issue", s_stall, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
            check1("stall_window", s_stall, k <= 5);
        end
        check32("stall_lo", bus.lo, 32'd12);

        // Flushed start is dropped; flush while busy does not abort.
        step(1'b1, MD_MULT, 32'd100, 32'd100, 1'b1, 1'b1);
        check1("flush_stall", s_stall, 1'b0);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check1("flush_no_busy", s_busy, 1'b0);
        check32("flush_lo_kept", bus.lo, 32'd12);
        step(1'b1, MD_DIVU, 32'd85, 32'd2, 1'b0, 1'b0);
        for (int k = 0; k < DC; k++) step(1'b0, MD_NONE, 32'd0, 32'd0, k[0], 1'b0);
        check32("flush_busy_hi", bus.hi, 32'd1);
        check32("flush_busy_lo", bus.lo, 32'd42);

        // Async reset three cycles into a divide discards the pending result.
        step(1'b1, MD_DIV, 32'd1000, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        pulse_reset();
        idle(DC + 2, 1'b0);
        check32("post_rst_hi", bus.hi, 32'd0);
        check32("post_rst_lo", bus.lo, 32'd0);

        // Randomized traffic; start is only offered when the model is idle.
        for (int i = 0; i < 400; i++) begin
            bit          st;
            logic [2:0]  op;
            logic [31:0] rs;
            logic [31:0] rt;
            st = (m_left == 0) && ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            step(st, op, rs, rt, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end
        idle(DC + 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
